// File: rtl/req_select_encoder_pkg.sv
// Shared types for the 8-to-3 request select encoder.
// Build option ROUND_ROBIN_EN selects rotating priority.
package kangaroo_logic_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    GRANT,
    RELEASE
  } enc_state_t;

  typedef logic [2:0] req_idx_t;

  localparam int N_REQ = 8;
endpackage

// File: rtl/req_select_encoder_if.sv
// Request/decoder-pin bundle for req_select_encoder.
// master = encoder side, slave = request source / decoder side.
interface req_select_encoder_if;
  import kangaroo_logic_pkg::*;

  logic             _EI;
  logic [N_REQ-1:0] _R;
  logic             _A;
  logic             _B;
  logic             _GRP;
  logic             _G;
  logic             _GS;
  logic             _EO;

  modport master (
    input  _EI, _R,
    output _A, _B, _GRP, _G, _GS, _EO
  );

  modport slave (
    output _EI, _R,
    input  _A, _B, _GRP, _G, _GS, _EO
  );
endinterface

// File: rtl/req_select_encoder_prio_pick.sv
// Combinational priority pick over active-high requests.
// Search runs from start, downward (DESCEND=1) or upward with wrap.
module prio_pick
  import kangaroo_logic_pkg::*;
#(
  parameter bit DESCEND = 1'b1
) (
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         start,
  output req_idx_t         idx,
  output logic             any
);

  req_idx_t cand;

  // Walk the search order backwards so the earliest hit is written last.
  always_comb begin
    idx  = start;
    any  = 1'b0;
    cand = start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = DESCEND ? start - req_idx_t'(i)
                     : start + req_idx_t'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_select_encoder.sv
// Sequential 8-to-3 request encoder/arbiter driving a dual 2-to-4 decoder.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed (highest wins).
module req_select_encoder
  import kangaroo_logic_pkg::*;
#(
  parameter int HOLD_MIN    = 1,
  parameter int DEAD_CYCLES = 1
) (
  input logic                  _CLK,
  input logic                  _RESET,
  req_select_encoder_if.master bus
);

  localparam int HW = $clog2(HOLD_MIN + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);

  enc_state_t       state, state_n;
  logic [N_REQ-1:0] req_q;
  req_idx_t         sel, sel_n;
  req_idx_t         win, start;
  logic             any;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [DW-1:0]    dead_cnt, dead_n;
  logic             g_n, gs_n, eo_n;

`ifdef ROUND_ROBIN_EN
  req_idx_t ptr;
  assign start = ptr + req_idx_t'(1);

  prio_pick #(.DESCEND(1'b0)) u_pick (
    .req   (~req_q),
    .start (start),
    .idx   (win),
    .any   (any)
  );

  always_ff @(posedge _CLK or posedge _RESET) begin
    if (_RESET)
      ptr <= req_idx_t'(7);
    else if (state == SETUP && state_n == GRANT)
      ptr <= sel;
  end
`else
  assign start = req_idx_t'(7);

  prio_pick #(.DESCEND(1'b1)) u_pick (
    .req   (~req_q),
    .start (start),
    .idx   (win),
    .any   (any)
  );
`endif

  always_comb begin
    state_n = state;
    sel_n   = sel;
    hold_n  = hold_cnt;
    dead_n  = dead_cnt;
    unique case (state)
      IDLE: begin
        if (!bus._EI && any) begin
          sel_n   = win;
          state_n = SETUP;
        end
      end
      SETUP: begin
        hold_n  = HW'(1);
        dead_n  = DW'(1);
        state_n = bus._EI ? RELEASE : GRANT;
      end
      GRANT: begin
        if (bus._EI ||
            (req_q[sel] && hold_cnt >= HW'(HOLD_MIN))) begin
          state_n = RELEASE;
          dead_n  = DW'(1);
        end else if (hold_cnt < HW'(HOLD_MIN)) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      RELEASE: begin
        if (dead_cnt >= DW'(DEAD_CYCLES))
          state_n = IDLE;
        else
          dead_n = dead_cnt + DW'(1);
      end
    endcase
  end

  // Pins lag the state by one edge; an abort lifts _G on that same edge.
  always_comb begin
    g_n  = !(state == GRANT && !bus._EI);
    gs_n = (state == IDLE);
    eo_n = !(state == IDLE && !bus._EI && !any);
  end

  always_ff @(posedge _CLK or posedge _RESET) begin
    if (_RESET) begin
      state    <= IDLE;
      req_q    <= '1;
      sel      <= '0;
      hold_cnt <= '0;
      dead_cnt <= '0;
      bus._A   <= 1'b0;
      bus._B   <= 1'b0;
      bus._GRP <= 1'b0;
      bus._G   <= 1'b1;
      bus._GS  <= 1'b1;
      bus._EO  <= 1'b1;
    end else begin
      state    <= state_n;
      req_q    <= bus._R;
      sel      <= sel_n;
      hold_cnt <= hold_n;
      dead_cnt <= dead_n;
      bus._A   <= sel[0];
      bus._B   <= sel[1];
      bus._GRP <= sel[2];
      bus._G   <= g_n;
      bus._GS  <= gs_n;
      bus._EO  <= eo_n;
    end
  end

endmodule

// File: tb/tb_req_select_encoder.sv
// Directed bench for req_select_encoder: per-edge vector table
// plus hand sequences for long hold and asynchronous reset.
module tb_req_select_encoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  req_select_encoder_if bus ();
  req_select_encoder_if bus4 ();

  req_select_encoder u_dut (
    ._CLK   (clk),
    ._RESET (rst),
    .bus    (bus)
  );

  req_select_encoder #(.HOLD_MIN(4)) u_dut4 (
    ._CLK   (clk),
    ._RESET (rst),
    .bus    (bus4)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] r;
    logic       ei;
    logic [2:0] idx;
    logic       g;
    logic       gs;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] r, logic ei, logic [2:0] idx,
                              logic g, logic gs, logic eo);
    vec_t v;
    v.r = r; v.ei = ei; v.idx = idx;
    v.g = g; v.gs = gs; v.eo = eo;
    return v;
  endfunction

  function automatic logic [5:0] obs();
    return {bus._GRP, bus._B, bus._A, bus._G, bus._GS, bus._EO};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [2:0] rr_idx;
  int         lows;
  int         n;
  logic [2:0] a4;
  bit         seen;

  initial begin
`ifdef ROUND_ROBIN_EN
    rr_idx = 3'd0;
`else
    rr_idx = 3'd7;
`endif
    // idle then index 5 for six edges
    vecs.push_back(mk(8'hFF, 0, 3'd0, 1, 1, 0));
    vecs.push_back(mk(8'hDF, 0, 3'd0, 1, 1, 0));
    vecs.push_back(mk(8'hDF, 0, 3'd0, 1, 1, 1));
    vecs.push_back(mk(8'hDF, 0, 3'd5, 1, 0, 1));
    vecs.push_back(mk(8'hDF, 0, 3'd5, 0, 0, 1));
    vecs.push_back(mk(8'hDF, 0, 3'd5, 0, 0, 1));
    vecs.push_back(mk(8'hDF, 0, 3'd5, 0, 0, 1));
    vecs.push_back(mk(8'hFF, 0, 3'd5, 0, 0, 1));
    vecs.push_back(mk(8'hFF, 0, 3'd5, 0, 0, 1));
    vecs.push_back(mk(8'hFF, 0, 3'd5, 1, 0, 1));
    vecs.push_back(mk(8'hFF, 0, 3'd5, 1, 1, 0));
    // indices 0 and 7 together
    vecs.push_back(mk(8'h7E, 0, 3'd5, 1, 1, 0));
    vecs.push_back(mk(8'h7E, 0, 3'd5, 1, 1, 1));
    vecs.push_back(mk(8'h7E, 0, 3'd7, 1, 0, 1));
    vecs.push_back(mk(8'hFF, 0, 3'd7, 0, 0, 1));
    vecs.push_back(mk(8'hFF, 0, 3'd7, 0, 0, 1));
    vecs.push_back(mk(8'hFF, 0, 3'd7, 1, 0, 1));
    vecs.push_back(mk(8'hFF, 0, 3'd7, 1, 1, 0));
    // index 0 aborted by _EI, then _EI blocks new grants
    vecs.push_back(mk(8'hFE, 0, 3'd7, 1, 1, 0));
    vecs.push_back(mk(8'hFE, 0, 3'd7, 1, 1, 1));
    vecs.push_back(mk(8'hFE, 0, 3'd0, 1, 0, 1));
    vecs.push_back(mk(8'hFE, 0, 3'd0, 0, 0, 1));
    vecs.push_back(mk(8'hFE, 1, 3'd0, 1, 0, 1));
    vecs.push_back(mk(8'hFE, 1, 3'd0, 1, 0, 1));
    vecs.push_back(mk(8'hFF, 1, 3'd0, 1, 1, 1));
    vecs.push_back(mk(8'hFF, 1, 3'd0, 1, 1, 1));
    vecs.push_back(mk(8'hFF, 0, 3'd0, 1, 1, 0));

    rst = 1'b1;
    bus._R = 8'hFF;  bus._EI = 1'b0;
    bus4._R = 8'hFF; bus4._EI = 1'b0;
    step();
    check("reset_state", obs(), {3'd0, 1'b1, 1'b1, 1'b1});
    step();
    check("reset_hold", obs(), {3'd0, 1'b1, 1'b1, 1'b1});
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus._R  = vecs[i].r;
      bus._EI = vecs[i].ei;
      step();
      check($sformatf("vec%0d", i), obs(),
            {vecs[i].idx, vecs[i].g, vecs[i].gs, vecs[i].eo});
    end

    // one-edge pulse on index 2 with HOLD_MIN=4
    bus4._R = 8'hFB;
    step();
    bus4._R = 8'hFF;
    lows = 0;
    seen = 1'b0;
    a4   = 3'd7;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus4._G === 1'b0) begin
        lows++;
        if (!seen) begin
          seen = 1'b1;
          a4 = {bus4._GRP, bus4._B, bus4._A};
        end
      end
    end
    check("hold4_low_cycles", lows, 4);
    check("hold4_addr", a4, 3'd2);
    check("hold4_idle", {bus4._G, bus4._GS}, 2'b11);

    // reset pulse in the middle of a grant
    bus._R  = 8'hFE;
    bus._EI = 1'b0;
    n = 0;
    while (bus._G !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    check("rst_grant_reached", bus._G, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", obs(), {3'd0, 1'b1, 1'b1, 1'b1});
    bus._R = 8'h7E;
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    step();
    check("rst_rearb_addr", obs(), {rr_idx, 1'b1, 1'b0, 1'b1});
    step();
    check("rst_rearb_g", obs(), {rr_idx, 1'b0, 1'b0, 1'b1});
    bus._R = 8'hFF;
    for (int i = 0; i < 5; i++) step();
    check("rst_final_idle", {bus._G, bus._GS, bus._EO}, 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
